// File: rtl/barrett_digit_feeder.sv
// barrett_digit_feeder
//
// Upstream sequencer for the digit-serial Barrett modular multiplier core.
// It accepts one operand set (A, B, M) and computes mu = floor(2^(n+m+3) / M)
// with a bit-serial restoring divider. It then pulses the core clear, streams
// B to the core as m-bit digits (most significant first) plus one zero flush
// digit, and finally pulses DONE in the cycle the core's Z_OUT is valid.
//
// Handshake: an operand set transfers on a rising edge where IN_VALID and
// IN_READY are both high. IN_READY is high only in IDLE and does not depend
// on IN_VALID. IN_VALID is ignored in every other state.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   IN_VALID/READY   operand handshake
//   A_IN, B_IN, M_IN multiplicand, multiplier, modulus (n bits each)
//   X, M             multiplicand / modulus to the core, held from CLR on
//   Y_i              current digit to the core (m bits)
//   mu               reduction constant (m+7 bits), saturated on overflow
//   CORE_RST         active-low clear to the core
//   DIG_VALID, LAST  Y_i is a live digit / is the zero flush digit
//   DONE, ERR        one-cycle pulses: result valid / zero modulus rejected
//   MU_OVF           quotient did not fit in m+7 bits; held until next accept
// All outputs are registered.

module barrett_digit_feeder #(
  parameter int n = 8,
  parameter int m = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [n-1:0]   A_IN,
  input  logic [n-1:0]   B_IN,
  input  logic [n-1:0]   M_IN,
  output logic [n-1:0]   X,
  output logic [m-1:0]   Y_i,
  output logic [n-1:0]   M,
  output logic [m+6:0]   mu,
  output logic           CORE_RST,
  output logic           DIG_VALID,
  output logic           LAST,
  output logic           DONE,
  output logic           ERR,
  output logic           MU_OVF
);

  generate
    if (m < 1 || (n % m) != 0) begin : g_bad_params
      $fatal(1, "barrett_digit_feeder: n must be a positive multiple of m");
    end
  endgenerate

  localparam int ND  = n / m;          // digits per operand
  localparam int QW  = n + m + 4;      // dividend / quotient width
  localparam int MUW = m + 7;          // mu width
  localparam int EW  = (QW > MUW) ? QW : MUW;
  localparam int CW  = $clog2(QW + 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_CLR, S_FEED, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n:0]      rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [n-1:0]    a_q, a_d, b_q, b_d, mod_q, mod_d;

  logic [n-1:0]    x_d, m_d;
  logic [m-1:0]    y_d;
  logic [MUW-1:0]  mu_d;
  logic            ready_d, core_rst_d, dig_valid_d, last_d, done_d, err_d, ovf_d;

  // Divider datapath: the dividend is a single 1 followed by zeros, so the
  // incoming dividend bit is 1 only on the first step.
  logic [n:0]      r_sh, r_sub;
  logic            qbit;
  logic [QW-1:0]   quo_nx;
  logic [EW-1:0]   q_ext;

  always_comb begin
    r_sh   = (rem_q << 1) | (n+1)'(cnt_q == '0);
    qbit   = (r_sh >= {1'b0, mod_q});
    r_sub  = r_sh - {1'b0, mod_q};
    quo_nx = (quo_q << 1) | QW'(qbit);
    q_ext  = EW'(quo_nx);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    a_d         = a_q;
    b_d         = b_q;
    mod_d       = mod_q;
    x_d         = X;
    m_d         = M;
    mu_d        = mu;
    ovf_d       = MU_OVF;
    y_d         = '0;
    dig_valid_d = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID && IN_READY) begin
          a_d   = A_IN;
          b_d   = B_IN;
          mod_d = M_IN;
          if (M_IN == '0) begin
            err_d = 1'b1;
          end else begin
            ovf_d   = 1'b0;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = '0;
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        rem_d = qbit ? r_sub : r_sh;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          // Last quotient bit: publish core operands and mu on the edge
          // into CLR so they are stable for the whole core operation.
          state_d = S_CLR;
          x_d     = a_q;
          m_d     = mod_q;
          if ((q_ext >> MUW) != '0) begin
            mu_d  = '1;
            ovf_d = 1'b1;
          end else begin
            mu_d  = q_ext[MUW-1:0];
          end
        end
      end

      S_CLR: begin
        // First digit goes out on the edge into FEED; cnt counts digits sent.
        state_d     = S_FEED;
        y_d         = b_q[n-1 -: m];
        b_d         = b_q << m;
        dig_valid_d = 1'b1;
        cnt_d       = CW'(1);
      end

      S_FEED: begin
        dig_valid_d = 1'b1;
        if (cnt_q == CW'(ND)) begin
          state_d = S_FLUSH;
          last_d  = 1'b1;
        end else begin
          y_d   = b_q[n-1 -: m];
          b_d   = b_q << m;
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d    = (state_d == S_IDLE);
    core_rst_d = (state_d != S_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mod_q     <= '0;
      IN_READY  <= 1'b0;
      X         <= '0;
      Y_i       <= '0;
      M         <= '0;
      mu        <= '0;
      CORE_RST  <= 1'b0;
      DIG_VALID <= 1'b0;
      LAST      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      MU_OVF    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mod_q     <= mod_d;
      IN_READY  <= ready_d;
      X         <= x_d;
      Y_i       <= y_d;
      M         <= m_d;
      mu        <= mu_d;
      CORE_RST  <= core_rst_d;
      DIG_VALID <= dig_valid_d;
      LAST      <= last_d;
      DONE      <= done_d;
      ERR       <= err_d;
      MU_OVF    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_barrett_digit_feeder.sv
// Directed bench for barrett_digit_feeder: an n=8/m=4 instance for the main
// sequences and an n=16/m=4 instance for the wider configuration.
// Cycle k (k >= 1) is observed #1 after the k-th rising edge following the
// accept edge.

module tb_barrett_digit_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  a_in, b_in, m_in, x_out, m_out;
  logic [3:0]  y_i;
  logic [10:0] mu;
  logic        core_rst, dig_valid, last, done, err, mu_ovf;

  logic        w_valid, w_ready;
  logic [15:0] w_a, w_b, w_m, w_x, w_mo;
  logic [3:0]  w_y;
  logic [10:0] w_mu;
  logic        w_core_rst, w_dig_valid, w_last, w_done, w_err, w_ovf;

  barrett_digit_feeder #(.n(8), .m(4)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A_IN(a_in), .B_IN(b_in), .M_IN(m_in),
    .X(x_out), .Y_i(y_i), .M(m_out), .mu(mu),
    .CORE_RST(core_rst), .DIG_VALID(dig_valid), .LAST(last),
    .DONE(done), .ERR(err), .MU_OVF(mu_ovf)
  );

  barrett_digit_feeder #(.n(16), .m(4)) dut16 (
    .CLK(clk), .RST(rst), .IN_VALID(w_valid), .IN_READY(w_ready),
    .A_IN(w_a), .B_IN(w_b), .M_IN(w_m),
    .X(w_x), .Y_i(w_y), .M(w_mo), .mu(w_mu),
    .CORE_RST(w_core_rst), .DIG_VALID(w_dig_valid), .LAST(w_last),
    .DONE(w_done), .ERR(w_err), .MU_OVF(w_ovf)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] md);
    a_in = a; b_in = b; m_in = md; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},     32'(in_ready), 0);
    check({tag, "_x"},         32'(x_out), 0);
    check({tag, "_y"},         32'(y_i), 0);
    check({tag, "_m"},         32'(m_out), 0);
    check({tag, "_mu"},        32'(mu), 0);
    check({tag, "_core_rst"},  32'(core_rst), 0);
    check({tag, "_dig_valid"}, 32'(dig_valid), 0);
    check({tag, "_last"},      32'(last), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_err"},       32'(err), 0);
    check({tag, "_ovf"},       32'(mu_ovf), 0);
  endtask

  // Observes cycles 1..21 of one n=8 operation; returns in cycle 21.
  task automatic check_op(input logic [7:0] a, input logic [7:0] md, input int emu,
                          input int eovf, input int d1, input int d0);
    for (int c = 1; c <= 16; c++) begin
      check("div_ready",     32'(in_ready), 0);
      check("div_core_rst",  32'(core_rst), 1);
      check("div_dig_valid", 32'(dig_valid), 0);
      check("div_done",      32'(done), 0);
      check("div_ovf_clr",   32'(mu_ovf), 0);
      tick();
    end
    check("clr_core_rst",  32'(core_rst), 0);
    check("clr_dig_valid", 32'(dig_valid), 0);
    check("clr_y",         32'(y_i), 0);
    check("clr_x",         32'(x_out), 32'(a));
    check("clr_m",         32'(m_out), 32'(md));
    check("clr_mu",        32'(mu), emu);
    check("clr_ovf",       32'(mu_ovf), eovf);
    tick();
    check("feed1_y",         32'(y_i), d1);
    check("feed1_dig_valid", 32'(dig_valid), 1);
    check("feed1_last",      32'(last), 0);
    check("feed1_core_rst",  32'(core_rst), 1);
    tick();
    check("feed0_y",         32'(y_i), d0);
    check("feed0_dig_valid", 32'(dig_valid), 1);
    check("feed0_last",      32'(last), 0);
    tick();
    check("flush_y",         32'(y_i), 0);
    check("flush_dig_valid", 32'(dig_valid), 1);
    check("flush_last",      32'(last), 1);
    check("flush_done",      32'(done), 0);
    tick();
    check("done_pulse",     32'(done), 1);
    check("done_ready",     32'(in_ready), 1);
    check("done_dig_valid", 32'(dig_valid), 0);
    check("done_last",      32'(last), 0);
    check("done_x_held",    32'(x_out), 32'(a));
    check("done_mu_held",   32'(mu), emu);
  endtask

  initial begin
    int digs16[4];
    digs16 = '{1, 2, 3, 4};
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; m_in = '0;
    w_valid = 1'b0; w_a = '0; w_b = '0; w_m = '0;

    // Reset values, then the first cycle after release.
    repeat (3) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();
    check("post_rst_ready",    32'(in_ready), 1);
    check("post_rst_core_rst", 32'(core_rst), 1);

    // Nominal operation.
    start_op(8'd100, 8'hA7, 8'd251);
    check_op(8'd100, 8'd251, 130, 0, 'hA, 'h7);
    tick();
    check("nom_done_end", 32'(done), 0);
    check("nom_ready",    32'(in_ready), 1);

    // Small moduli: largest non-overflowing mu and saturation.
    start_op(8'd3, 8'h5E, 8'd17);
    check_op(8'd3, 8'd17, 1927, 0, 'h5, 'hE);
    tick();
    start_op(8'd9, 8'h0F, 8'd16);
    check_op(8'd9, 8'd16, 2047, 1, 'h0, 'hF);
    tick();
    check("ovf_held", 32'(mu_ovf), 1);

    // Zero modulus is rejected without starting.
    start_op(8'd7, 8'h11, 8'd0);
    check("zero_err",      32'(err), 1);
    check("zero_ready",    32'(in_ready), 1);
    check("zero_core_rst", 32'(core_rst), 1);
    tick();
    check("zero_err_end",   32'(err), 0);
    check("zero_ready2",    32'(in_ready), 1);
    check("zero_core_rst2", 32'(core_rst), 1);
    check("zero_dig_valid", 32'(dig_valid), 0);

    // Back-to-back: second set held valid during the whole first operation.
    a_in = 8'd100; b_in = 8'hA7; m_in = 8'd251; in_valid = 1'b1;
    tick();
    a_in = 8'd50; b_in = 8'h3C; m_in = 8'd200;
    check_op(8'd100, 8'd251, 130, 0, 'hA, 'h7);
    tick();
    in_valid = 1'b0;
    check_op(8'd50, 8'd200, 163, 0, 'h3, 'hC);
    tick();

    // Reset in cycle 18 aborts the operation.
    start_op(8'd100, 8'hA7, 8'd251);
    repeat (17) tick();
    check("abort_feed_y", 32'(y_i), 'hA);
    rst = 1'b1;
    tick();
    check_reset_vals("abort");
    rst = 1'b0;
    tick();
    check("abort_ready",    32'(in_ready), 1);
    check("abort_core_rst", 32'(core_rst), 1);
    check("abort_no_done0", 32'(done), 0);
    tick();
    check("abort_no_done1", 32'(done), 0);
    start_op(8'd3, 8'h5E, 8'd17);
    check_op(8'd3, 8'd17, 1927, 0, 'h5, 'hE);
    tick();

    // Wider configuration n=16, m=4: DIV 1..24, CLR 25, FEED 26..29,
    // FLUSH 30, DONE 31.
    w_a = 16'h0101; w_b = 16'h1234; w_m = 16'hFFF1; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check("w_div_core_rst", 32'(w_core_rst), 1);
      check("w_div_ready",    32'(w_ready), 0);
      check("w_div_dig",      32'(w_dig_valid), 0);
      tick();
    end
    check("w_clr_core_rst", 32'(w_core_rst), 0);
    check("w_clr_mu",       32'(w_mu), 128);
    check("w_clr_ovf",      32'(w_ovf), 0);
    check("w_clr_m",        32'(w_mo), 'hFFF1);
    check("w_clr_x",        32'(w_x), 'h0101);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("w_feed_y",    32'(w_y), digs16[k]);
      check("w_feed_dig",  32'(w_dig_valid), 1);
      check("w_feed_last", 32'(w_last), 0);
      tick();
    end
    check("w_flush_y",    32'(w_y), 0);
    check("w_flush_last", 32'(w_last), 1);
    check("w_flush_dig",  32'(w_dig_valid), 1);
    tick();
    check("w_done",       32'(w_done), 1);
    check("w_done_ready", 32'(w_ready), 1);
    check("w_err",        32'(w_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
